reg_pipe: RTL and testbench
===========================

REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4, number of register stages; SHALL be >= 1.
REQ-003 Parameter RST_VAL, default 0 (WIDTH bits), value loaded into every data register on reset.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous clear of all stage valid flags.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 in_data  input  WIDTH  upstream word.
REQ-010 out_valid  output  1  last stage holds a word.
REQ-011 out_ready  input  1  downstream accepts the word this cycle.
REQ-012 out_data  output  WIDTH  last-stage word.
REQ-013 count  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 Each stage SHALL hold one valid bit and one WIDTH-bit data register.
REQ-015 Transfers: input on in_valid && in_ready; output on out_valid && out_ready; stage-to-stage when the source is valid and the destination is ready.
REQ-016 Stage ready = !valid || downstream ready (bubble collapsing); the last stage's downstream ready is out_ready.
REQ-017 in_ready SHALL equal stage-0 ready && !flush.
REQ-018 A stage's data register SHALL load only when it accepts a word; otherwise it SHALL hold its value.
REQ-019 Latency: a word accepted in cycle N with no stall SHALL appear on out_data with out_valid=1 in cycle N+DEPTH.
REQ-020 Throughput: with out_ready held at 1, one word per cycle SHALL be sustained with no bubbles.
REQ-021 Ordering SHALL be strictly FIFO; no word may be dropped or duplicated.
REQ-022 Full (count=DEPTH) with out_ready=1: input accept and output pop SHALL occur in the same cycle, and count SHALL stay at DEPTH.
REQ-023 Full with out_ready=0: in_ready SHALL be 0, and all stages SHALL hold.
REQ-024 Empty: out_valid SHALL be 0, and out_data SHALL hold its last value (RST_VAL after reset).
REQ-025 count SHALL be a registered value, next = count + accept - pop (unless flushing), and SHALL never exceed DEPTH or go below 0.
REQ-026 flush=1: all valid bits and count SHALL clear at the next edge, and data registers SHALL hold their values.
REQ-027 flush=1: an input word presented in the same cycle SHALL be ignored, and an output pop in the same cycle SHALL still count as delivered.

Reset
REQ-028 rst=0 SHALL immediately, without waiting for a clock edge, clear all valid bits and count to 0, and load every data register with RST_VAL.
REQ-029 During reset: out_valid=0, out_data=RST_VAL, count=0, and in_ready=0.
REQ-030 Reset mid-stream SHALL discard all in-flight words.
REQ-031 The first accept after reset release SHALL be possible on the first rising edge with rst=1.

Structure
REQ-032 Package reg_pipe_pkg SHALL hold the default WIDTH/DEPTH constants and the count-width helper function.
REQ-033 Sub-module reg_pipe_stage (one valid+data stage with valid/ready ports, WIDTH and RST_VAL parameters) SHALL be instantiated DEPTH times via generate.
REQ-034 The design SHALL contain no latches.
REQ-035 Combinational paths SHALL be limited to the ready chain out_ready -> in_ready.

Verification (WIDTH=8, DEPTH=4, RST_VAL=0)
REQ-036 Assert rst=0 with clk stopped -> out_valid=0, out_data=0x00, count=0 immediately; release rst -> in_ready=1.
REQ-037 Stream 0x01..0x08 on consecutive cycles with out_ready=1 -> 0x01 is output 4 cycles after its accept, then one word per cycle, in order, with no gaps.
REQ-038 out_ready=0 while offering 6 words -> 4 accepted, in_ready=0, count=4; then out_ready=1 -> outputs 0x01..0x06 in order, and count returns to 0.
REQ-039 Full with out_ready=1 and in_valid=1 with 0x99 -> one pop and one accept in the same cycle, count stays 4, and 0x99 emerges 4 cycles later.
REQ-040 With count=3, flush=1 and in_valid=1 with 0x77 -> next cycle count=0 and out_valid=0, and 0x77 never appears.
REQ-041 rst=0 asserted asynchronously between edges with count=2 -> count=0 and out_valid=0 before the next edge, and no stale word is output after release.

Source files
------------

// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the valid/ready register pipeline.
// Defaults here are the parameter defaults of the interface and the top.
package reg_pipe_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   // Bits needed to hold an occupancy value of 0..depth inclusive.
   function automatic int count_w(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/reg_pipe_if.sv
// Handshake bundle for reg_pipe: upstream/downstream valid-ready buses,
// flush request and occupancy readback.
interface reg_pipe_if
   import reg_pipe_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);

   localparam int CW = count_w(DEPTH);

   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0]    count;

   modport master (
      output flush,
      output in_valid,
      input  in_ready,
      output in_data,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  count
   );

   modport slave (
      input  flush,
      input  in_valid,
      output in_ready,
      input  in_data,
      output out_valid,
      input  out_ready,
      output out_data,
      output count
   );

endinterface

// File: rtl/reg_pipe_stage.sv
// One pipeline slot: a valid flag plus a data register with valid/ready
// handshakes on both sides; the data register loads only on accept.
module reg_pipe_stage #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   input  logic             i_ready
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic             w_accept;
   logic             w_pop;

   // Empty slot, or one that drains this cycle, can take a new word.
   assign o_ready  = !r_valid || i_ready;
   assign w_accept = i_valid && o_ready && !i_flush;
   assign w_pop    = r_valid && i_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_data  <= RST_VAL;
      end else begin
         if (i_flush)
            r_valid <= 1'b0;
         else if (w_accept)
            r_valid <= 1'b1;
         else if (w_pop)
            r_valid <= 1'b0;
         if (w_accept)
            r_data <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/reg_pipe.sv
// Bubble-collapsing valid/ready register pipeline of DEPTH slots with a
// synchronous flush and a registered occupancy count.
module reg_pipe
   import reg_pipe_pkg::*;
#(
   parameter int               WIDTH   = DEF_WIDTH,
   parameter int               DEPTH   = DEF_DEPTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic       clk,
   input  logic       rst,
   reg_pipe_if.slave  bus
);

   localparam int CW = count_w(DEPTH);

   logic [DEPTH:0]   w_vld;
   logic [WIDTH-1:0] w_data [DEPTH+1];
   logic [DEPTH-1:0] w_rdy_up;
   logic [DEPTH-1:0] w_rdy_dn;
   logic             w_unused_rdy;
   logic             w_accept;
   logic             w_pop;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_count_nxt;

   assign w_vld[0]  = bus.in_valid;
   assign w_data[0] = bus.in_data;

   // Downstream ready of each slot, built from registered valids so the
   // only combinational path is out_ready through to in_ready.
   always_comb begin
      w_rdy_dn            = '0;
      w_rdy_dn[DEPTH-1]   = bus.out_ready;
      for (int i = DEPTH - 2; i >= 0; i--)
         w_rdy_dn[i] = !w_vld[i+2] || w_rdy_dn[i+1];
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      reg_pipe_stage #(
         .WIDTH   (WIDTH),
         .RST_VAL (RST_VAL)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .i_flush (bus.flush),
         .i_valid (w_vld[g]),
         .i_data  (w_data[g]),
         .o_ready (w_rdy_up[g]),
         .o_valid (w_vld[g+1]),
         .o_data  (w_data[g+1]),
         .i_ready (w_rdy_dn[g])
      );
   end

   // Only slot 0's upstream ready faces the outside world.
   assign w_unused_rdy = ^w_rdy_up;

   assign bus.in_ready  = w_rdy_up[0] && !bus.flush && rst;
   assign bus.out_valid = w_vld[DEPTH];
   assign bus.out_data  = w_data[DEPTH];

   assign w_accept = bus.in_valid && bus.in_ready;
   assign w_pop    = bus.out_valid && bus.out_ready;

   always_comb begin
      w_count_nxt = r_count;
      if (bus.flush)
         w_count_nxt = '0;
      else if (w_accept && !w_pop)
         w_count_nxt = r_count + CW'(1);
      else if (!w_accept && w_pop)
         w_count_nxt = r_count - CW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_count <= '0;
      else
         r_count <= w_count_nxt;
   end

   assign bus.count = r_count;

endmodule

// File: tb/tb_reg_pipe.sv
// Directed bench for reg_pipe (WIDTH=8, DEPTH=4, RST_VAL=0): vector table
// plus hand-written reset sequences.
module tb_reg_pipe;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic clk_en = 1'b0;

   always #5 if (clk_en) clk = ~clk;

   reg_pipe_if #(.WIDTH(8), .DEPTH(4)) bus ();

   reg_pipe #(
      .WIDTH   (8),
      .DEPTH   (4),
      .RST_VAL (8'h00)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       iv;
      logic [7:0] id;
      logic       ordy;
      logic       fl;
      logic       ev;
      logic [7:0] ed;
      logic [2:0] ec;
      logic       eir;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic add(input logic iv, input logic [7:0] id, input logic ordy,
                      input logic fl, input logic ev, input logic [7:0] ed,
                      input logic [2:0] ec, input logic eir);
      vec_t v;
      v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
      v.ev = ev; v.ed = ed; v.ec = ec; v.eir = eir;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.out_ready = 1'b0;

      // stream 0x01..0x08, out_ready high
      add(1, 8'h01, 1, 0, 0, 8'h00, 0, 1);
      add(1, 8'h02, 1, 0, 0, 8'h00, 1, 1);
      add(1, 8'h03, 1, 0, 0, 8'h00, 2, 1);
      add(1, 8'h04, 1, 0, 0, 8'h00, 3, 1);
      add(1, 8'h05, 1, 0, 1, 8'h01, 4, 1);
      add(1, 8'h06, 1, 0, 1, 8'h02, 4, 1);
      add(1, 8'h07, 1, 0, 1, 8'h03, 4, 1);
      add(1, 8'h08, 1, 0, 1, 8'h04, 4, 1);
      add(0, 8'h00, 1, 0, 1, 8'h05, 4, 1);
      add(0, 8'h00, 1, 0, 1, 8'h06, 3, 1);
      add(0, 8'h00, 1, 0, 1, 8'h07, 2, 1);
      add(0, 8'h00, 1, 0, 1, 8'h08, 1, 1);
      add(0, 8'h00, 1, 0, 0, 8'h08, 0, 1);
      // stall: 6 words offered, 4 accepted, then drain
      add(1, 8'h01, 0, 0, 0, 8'h08, 0, 1);
      add(1, 8'h02, 0, 0, 0, 8'h08, 1, 1);
      add(1, 8'h03, 0, 0, 0, 8'h08, 2, 1);
      add(1, 8'h04, 0, 0, 0, 8'h08, 3, 1);
      add(1, 8'h05, 0, 0, 1, 8'h01, 4, 0);
      add(1, 8'h05, 0, 0, 1, 8'h01, 4, 0);
      add(1, 8'h05, 1, 0, 1, 8'h01, 4, 1);
      add(1, 8'h06, 1, 0, 1, 8'h02, 4, 1);
      add(0, 8'h00, 1, 0, 1, 8'h03, 4, 1);
      add(0, 8'h00, 1, 0, 1, 8'h04, 3, 1);
      add(0, 8'h00, 1, 0, 1, 8'h05, 2, 1);
      add(0, 8'h00, 1, 0, 1, 8'h06, 1, 1);
      add(0, 8'h00, 1, 0, 0, 8'h06, 0, 1);
      // full, simultaneous pop + accept of 0x99
      add(1, 8'h11, 0, 0, 0, 8'h06, 0, 1);
      add(1, 8'h22, 0, 0, 0, 8'h06, 1, 1);
      add(1, 8'h33, 0, 0, 0, 8'h06, 2, 1);
      add(1, 8'h44, 0, 0, 0, 8'h06, 3, 1);
      add(1, 8'h99, 1, 0, 1, 8'h11, 4, 1);
      add(0, 8'h00, 1, 0, 1, 8'h22, 4, 1);
      add(0, 8'h00, 1, 0, 1, 8'h33, 3, 1);
      add(0, 8'h00, 1, 0, 1, 8'h44, 2, 1);
      add(0, 8'h00, 1, 0, 1, 8'h99, 1, 1);
      add(0, 8'h00, 1, 0, 0, 8'h99, 0, 1);
      // flush with count=3 while 0x77 offered
      add(1, 8'hA1, 0, 0, 0, 8'h99, 0, 1);
      add(1, 8'hA2, 0, 0, 0, 8'h99, 1, 1);
      add(1, 8'hA3, 0, 0, 0, 8'h99, 2, 1);
      add(1, 8'h77, 0, 1, 0, 8'h99, 3, 0);
      add(0, 8'h00, 1, 0, 0, 8'h99, 0, 1);
      add(0, 8'h00, 1, 0, 0, 8'h99, 0, 1);
      add(0, 8'h00, 1, 0, 0, 8'h99, 0, 1);
      add(0, 8'h00, 1, 0, 0, 8'h99, 0, 1);
      add(0, 8'h00, 1, 0, 0, 8'h99, 0, 1);

      // reset with clock stopped
      #5 rst = 1'b0;
      #1;
      chk("rst_out_valid", 0, 32'(bus.out_valid), 0);
      chk("rst_out_data",  0, 32'(bus.out_data),  0);
      chk("rst_count",     0, 32'(bus.count),     0);
      chk("rst_in_ready",  0, 32'(bus.in_ready),  0);
      clk_en = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rel_in_ready", 0, 32'(bus.in_ready), 1);
      step();

      foreach (tbl[i]) begin
         bus.in_valid  = tbl[i].iv;
         bus.in_data   = tbl[i].id;
         bus.out_ready = tbl[i].ordy;
         bus.flush     = tbl[i].fl;
         #1;
         chk("out_valid", i, 32'(bus.out_valid), 32'(tbl[i].ev));
         chk("out_data",  i, 32'(bus.out_data),  32'(tbl[i].ed));
         chk("count",     i, 32'(bus.count),     32'(tbl[i].ec));
         chk("in_ready",  i, 32'(bus.in_ready),  32'(tbl[i].eir));
         step();
      end
      bus.flush = 1'b0;

      // async reset mid-stream with two words in flight
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h55;
      step();
      bus.in_data   = 8'h66;
      step();
      bus.in_valid  = 1'b0;
      #1;
      chk("pre_rst_count", 0, 32'(bus.count), 2);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_count",     0, 32'(bus.count),     0);
      chk("mid_rst_out_valid", 0, 32'(bus.out_valid), 0);
      chk("mid_rst_out_data",  0, 32'(bus.out_data),  0);
      chk("mid_rst_in_ready",  0, 32'(bus.in_ready),  0);
      step();

      // release mid-cycle with a word offered: first edge must accept it
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h5A;
      bus.out_ready = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("post_rel_in_ready", 0, 32'(bus.in_ready), 1);
      step();
      bus.in_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         #1;
         chk("post_rel_out_valid", k, 32'(bus.out_valid), (k == 4) ? 1 : 0);
         chk("post_rel_count",     k, 32'(bus.count),     (k == 5) ? 0 : 1);
         if (k == 4)
            chk("post_rel_out_data", k, 32'(bus.out_data), 32'h5A);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
